instruction_fetch: RTL and testbench

INSTRUCTION_FETCH -- requirements
Module: instruction_fetch

---
 rtl/instruction_fetch_pkg.sv | 38 +++
 rtl/instruction_fetch_if.sv | 47 ++++
 rtl/instruction_fetch.sv | 119 +++++++++++
 tb/tb_instruction_fetch.sv | 216 +++++++++++++++++++++
 4 files changed

// File: rtl/instruction_fetch_pkg.sv
// -----------------------------------------------------------------------------
// instruction_fetch_pkg
// Shared processor definitions: default field widths, the halt opcode, the
// fetch FSM state encoding and the packed instruction layout. Imported by the
// fetch unit, its bus interface, and the decoder / sign-extension blocks.
// -----------------------------------------------------------------------------
package instruction_fetch_pkg;

  localparam int DEF_NB_PC      = 11;
  localparam int DEF_NB_INSTR   = 16;
  localparam int DEF_NB_OPCODE  = 5;
  localparam int DEF_NB_OPERAND = 11;

  localparam logic [DEF_NB_OPCODE-1:0] DEF_HALT_OPCODE = 5'b00000;

  // Fetch sequencer states; HALTED is parked until a new start pulse.
  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_FETCH  = 3'd1,
    ST_WAIT   = 3'd2,
    ST_ISSUE  = 3'd3,
    ST_HALTED = 3'd4
  } fetch_state_t;

  // Instruction word layout at the default widths: opcode on the top bits,
  // operand (sign-extension input) on the bottom bits.
  typedef struct packed {
    logic [DEF_NB_OPCODE-1:0]  opcode;
    logic [DEF_NB_OPERAND-1:0] operand;
  } instr_t;

  // True when an opcode is the configured halt opcode.
  function automatic logic is_halt(input logic [DEF_NB_OPCODE-1:0] opcode,
                                   input logic [DEF_NB_OPCODE-1:0] halt_opcode);
    return (opcode == halt_opcode);
  endfunction

endpackage

// File: rtl/instruction_fetch_if.sv
// -----------------------------------------------------------------------------
// instruction_fetch_if
// Bus bundle between the fetch unit and its environment (program memory,
// control, downstream decoder).
//   i_start     : one-cycle start pulse
//   o_pm_addr   : program-memory read address
//   o_pm_rd_en  : program-memory read strobe
//   i_pm_data   : program-memory data, valid the cycle after o_pm_rd_en
//   o_opcode    : issued opcode field
//   o_operand   : issued operand field
//   o_pc        : address of the issued instruction
//   o_valid     : issued instruction valid
//   i_ready     : downstream accepts the issued instruction
//   o_halted    : fetch unit parked after a halt instruction
// modport master = the fetch unit, modport slave = its environment.
// -----------------------------------------------------------------------------
interface instruction_fetch_if
  import instruction_fetch_pkg::*;
#(
  parameter int NB_PC      = DEF_NB_PC,
  parameter int NB_INSTR   = DEF_NB_INSTR,
  parameter int NB_OPCODE  = DEF_NB_OPCODE,
  parameter int NB_OPERAND = DEF_NB_OPERAND
);

  logic                  i_start;
  logic [NB_PC-1:0]      o_pm_addr;
  logic                  o_pm_rd_en;
  logic [NB_INSTR-1:0]   i_pm_data;
  logic [NB_OPCODE-1:0]  o_opcode;
  logic [NB_OPERAND-1:0] o_operand;
  logic [NB_PC-1:0]      o_pc;
  logic                  o_valid;
  logic                  i_ready;
  logic                  o_halted;

  modport master (
    input  i_start, i_pm_data, i_ready,
    output o_pm_addr, o_pm_rd_en, o_opcode, o_operand, o_pc, o_valid, o_halted
  );

  modport slave (
    output i_start, i_pm_data, i_ready,
    input  o_pm_addr, o_pm_rd_en, o_opcode, o_operand, o_pc, o_valid, o_halted
  );

endinterface

// File: rtl/instruction_fetch.sv
// -----------------------------------------------------------------------------
// instruction_fetch
// Sequential fetch unit: IDLE -> FETCH -> WAIT -> ISSUE -> (FETCH | HALTED).
// One memory read per instruction, one instruction per three cycles when the
// downstream is always ready. A halt opcode is issued like any other
// instruction and then parks the unit in HALTED until the next start pulse.
// Ports:
//   i_clock : system clock, rising edge
//   i_reset : asynchronous active-high reset
//   bus     : instruction_fetch_if.master (memory, control, issue handshake)
// All bus outputs come straight from registers.
// -----------------------------------------------------------------------------
module instruction_fetch
  import instruction_fetch_pkg::*;
#(
  parameter int                   NB_PC       = DEF_NB_PC,
  parameter int                   NB_INSTR    = DEF_NB_INSTR,
  parameter int                   NB_OPCODE   = DEF_NB_OPCODE,
  parameter int                   NB_OPERAND  = DEF_NB_OPERAND,
  parameter logic [NB_OPCODE-1:0] HALT_OPCODE = NB_OPCODE'(DEF_HALT_OPCODE)
) (
  input logic                 i_clock,
  input logic                 i_reset,
  instruction_fetch_if.master bus
);

  fetch_state_t          state_r;
  logic [NB_PC-1:0]      pc_r;
  logic [NB_PC-1:0]      pm_addr_r;
  logic [NB_INSTR-1:0]   ir_r;
  logic                  pm_rd_en_r;
  logic                  valid_r;
  logic                  halted_r;

  logic [NB_PC-1:0]      pc_inc_s;
  logic [NB_OPCODE-1:0]  opcode_s;
  logic [NB_OPERAND-1:0] operand_s;
  logic                  accept_s;

  // Next sequential address; natural overflow gives the 0x7FF -> 0x000 wrap.
  assign pc_inc_s  = pc_r + NB_PC'(1);
  assign opcode_s  = ir_r[NB_INSTR-1 -: NB_OPCODE];
  assign operand_s = ir_r[NB_OPERAND-1:0];
  assign accept_s  = valid_r & bus.i_ready;

  // Fetch sequencer with PC, instruction register and all registered outputs.
  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      state_r    <= ST_IDLE;
      pc_r       <= '0;
      pm_addr_r  <= '0;
      ir_r       <= '0;
      pm_rd_en_r <= 1'b0;
      valid_r    <= 1'b0;
      halted_r   <= 1'b0;
    end else begin
      case (state_r)
        ST_IDLE, ST_HALTED: begin
          if (bus.i_start) begin
            // Restart always begins at address 0; the read strobe is raised
            // here so it is high exactly while the FSM sits in FETCH.
            pc_r       <= '0;
            pm_addr_r  <= '0;
            pm_rd_en_r <= 1'b1;
            halted_r   <= 1'b0;
            state_r    <= ST_FETCH;
          end else begin
            state_r    <= state_r;
          end
        end
        ST_FETCH: begin
          pm_rd_en_r <= 1'b0;
          state_r    <= ST_WAIT;
        end
        ST_WAIT: begin
          // Memory data is valid during this cycle; capture it at the closing edge.
          ir_r    <= bus.i_pm_data;
          valid_r <= 1'b1;
          state_r <= ST_ISSUE;
        end
        ST_ISSUE: begin
          if (accept_s) begin
            valid_r <= 1'b0;
            if (opcode_s == HALT_OPCODE) begin
              halted_r <= 1'b1;
              state_r  <= ST_HALTED;
            end else begin
              pc_r       <= pc_inc_s;
              pm_addr_r  <= pc_inc_s;
              pm_rd_en_r <= 1'b1;
              state_r    <= ST_FETCH;
            end
          end else begin
            state_r <= ST_ISSUE;
          end
        end
        default: begin
          // Unreachable encodings fall back to a clean idle state.
          state_r    <= ST_IDLE;
          pc_r       <= '0;
          pm_addr_r  <= '0;
          ir_r       <= '0;
          pm_rd_en_r <= 1'b0;
          valid_r    <= 1'b0;
          halted_r   <= 1'b0;
        end
      endcase
    end
  end

  assign bus.o_pm_addr  = pm_addr_r;
  assign bus.o_pm_rd_en = pm_rd_en_r;
  assign bus.o_opcode   = opcode_s;
  assign bus.o_operand  = operand_s;
  assign bus.o_pc       = pc_r;
  assign bus.o_valid    = valid_r;
  assign bus.o_halted   = halted_r;

endmodule

// File: tb/tb_instruction_fetch.sv
// -----------------------------------------------------------------------------
// tb_instruction_fetch
// Self-checking bench: a program memory model answers read strobes one cycle
// later (and drives noise otherwise); a reference model walks the program as
// a list of (pc, opcode, operand) issues and the bench checks each issue,
// its latency, stall stability, the halt behaviour and reset behaviour.
// -----------------------------------------------------------------------------
module tb_instruction_fetch;

  localparam int           PM_DEPTH = 2048;
  localparam logic [4:0]   HALT_OP  = 5'b00000;

  logic        clk;
  logic        rst;
  logic        start_r;
  logic        ready_r;
  logic [15:0] pm_data_r;
  logic [15:0] mem [0:PM_DEPTH-1];

  int n_checks;
  int n_fail;

  instruction_fetch_if bus_if ();

  assign bus_if.i_start   = start_r;
  assign bus_if.i_ready   = ready_r;
  assign bus_if.i_pm_data = pm_data_r;

  instruction_fetch dut (
    .i_clock (clk),
    .i_reset (rst),
    .bus     (bus_if.master)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Program memory: data for a strobed address appears the following cycle,
  // noise every other cycle so a mistimed capture is visible.
  always @(posedge clk) begin
    if (bus_if.o_pm_rd_en) pm_data_r <= mem[bus_if.o_pm_addr];
    else                   pm_data_r <= 16'($urandom);
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_checks++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", tag, got, want);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Random non-halt program, with a halt word at halt_at (none if negative).
  task automatic fill_program(input int halt_at);
    for (int i = 0; i < PM_DEPTH; i++)
      mem[i] = {5'($urandom_range(1, 31)), 11'($urandom)};
    if (halt_at >= 0) mem[halt_at] = {HALT_OP, 11'($urandom)};
  endtask

  // Start the unit and follow the program against the reference issue list.
  task automatic run_program(input int stall_min, input int stall_max, input int max_issues);
    int          q_pc[$];
    logic [15:0] q_w[$];
    int          pc;
    int          cyc;
    int          stall;
    logic [15:0] w;
    bit          is_last_halt;

    // Reference model: sequential walk, stop after the halt word is issued.
    pc = 0;
    for (int n = 0; n < max_issues; n++) begin
      q_pc.push_back(pc);
      q_w.push_back(mem[pc]);
      if (mem[pc][15:11] == HALT_OP) break;
      pc = (pc + 1) % PM_DEPTH;
    end

    ready_r = 1'b0;
    start_r = 1'b1;
    tick();
    start_r = 1'b0;
    check_eq("start_rd_en",  32'(bus_if.o_pm_rd_en), 32'd1);
    check_eq("start_addr",   32'(bus_if.o_pm_addr),  32'd0);
    check_eq("start_halted", 32'(bus_if.o_halted),   32'd0);

    for (int k = 0; k < q_pc.size(); k++) begin
      w   = q_w[k];
      cyc = 1;
      while (!bus_if.o_valid && cyc < 8) begin
        start_r = ($urandom_range(0, 3) == 0);
        tick();
        cyc++;
      end
      start_r = 1'b0;
      check_eq("issue_latency", 32'(cyc), 32'd3);
      if (!bus_if.o_valid) return;
      check_eq("issue_pc",      32'(bus_if.o_pc),      32'(q_pc[k]));
      check_eq("issue_opcode",  32'(bus_if.o_opcode),  32'(w[15:11]));
      check_eq("issue_operand", 32'(bus_if.o_operand), 32'(w[10:0]));

      stall = $urandom_range(stall_min, stall_max);
      for (int s = 0; s < stall; s++) begin
        start_r = ($urandom_range(0, 3) == 0);
        tick();
        check_eq("stall_valid",   32'(bus_if.o_valid),    32'd1);
        check_eq("stall_rd_en",   32'(bus_if.o_pm_rd_en), 32'd0);
        check_eq("stall_pc",      32'(bus_if.o_pc),       32'(q_pc[k]));
        check_eq("stall_opcode",  32'(bus_if.o_opcode),   32'(w[15:11]));
        check_eq("stall_operand", 32'(bus_if.o_operand),  32'(w[10:0]));
      end

      ready_r = 1'b1;
      start_r = ($urandom_range(0, 3) == 0);
      tick();
      ready_r = 1'b0;
      start_r = 1'b0;
      is_last_halt = (w[15:11] == HALT_OP);
      check_eq("accept_valid_low", 32'(bus_if.o_valid), 32'd0);
      if (is_last_halt) begin
        check_eq("halt_halted", 32'(bus_if.o_halted),   32'd1);
        check_eq("halt_rd_en",  32'(bus_if.o_pm_rd_en), 32'd0);
        repeat (2) tick();
        check_eq("halt_hold",   32'(bus_if.o_halted),   32'd1);
        check_eq("halt_no_rd",  32'(bus_if.o_pm_rd_en), 32'd0);
      end else begin
        check_eq("next_rd_en", 32'(bus_if.o_pm_rd_en), 32'd1);
        check_eq("next_addr",  32'(bus_if.o_pm_addr),  32'((q_pc[k] + 1) % PM_DEPTH));
      end
    end
  endtask

  task automatic apply_reset();
    rst = 1'b1;
    repeat (2) tick();
    rst = 1'b0;
    tick();
  endtask

  initial begin
    n_checks  = 0;
    n_fail    = 0;
    rst       = 1'b1;
    start_r   = 1'b0;
    ready_r   = 1'b0;
    pm_data_r = 16'h0000;
    for (int i = 0; i < PM_DEPTH; i++) mem[i] = 16'h0000;

    // Reset state.
    repeat (2) tick();
    check_eq("rst_valid",   32'(bus_if.o_valid),    32'd0);
    check_eq("rst_rd_en",   32'(bus_if.o_pm_rd_en), 32'd0);
    check_eq("rst_halted",  32'(bus_if.o_halted),   32'd0);
    check_eq("rst_addr",    32'(bus_if.o_pm_addr),  32'd0);
    check_eq("rst_opcode",  32'(bus_if.o_opcode),   32'd0);
    check_eq("rst_operand", 32'(bus_if.o_operand),  32'd0);
    check_eq("rst_pc",      32'(bus_if.o_pc),       32'd0);
    rst = 1'b0;
    repeat (2) tick();
    check_eq("idle_no_rd",  32'(bus_if.o_pm_rd_en), 32'd0);

    // Three-word directed program, then the same with 5-cycle stalls,
    // restarted from HALTED.
    fill_program(-1);
    mem[0] = 16'h0805;
    mem[1] = 16'h1FFF;
    mem[2] = 16'h0000;
    run_program(0, 0, 16);
    run_program(5, 5, 16);

    // Random programs with the halt at a random address.
    for (int r = 0; r < 4; r++) begin
      fill_program($urandom_range(3, 40));
      run_program(0, 3, 64);
    end

    // Reset while an instruction is being issued.
    fill_program(-1);
    mem[0] = {5'd9, 11'h2A5};
    start_r = 1'b1;
    tick();
    start_r = 1'b0;
    repeat (2) tick();
    check_eq("pre_rst_valid", 32'(bus_if.o_valid), 32'd1);
    #3;
    rst = 1'b1;
    #1;
    check_eq("mid_rst_valid",   32'(bus_if.o_valid),    32'd0);
    check_eq("mid_rst_pc",      32'(bus_if.o_pc),       32'd0);
    check_eq("mid_rst_opcode",  32'(bus_if.o_opcode),   32'd0);
    check_eq("mid_rst_operand", 32'(bus_if.o_operand),  32'd0);
    check_eq("mid_rst_rd_en",   32'(bus_if.o_pm_rd_en), 32'd0);
    tick();
    rst = 1'b0;
    repeat (2) tick();
    check_eq("post_rst_idle_rd", 32'(bus_if.o_pm_rd_en), 32'd0);
    check_eq("post_rst_idle_v",  32'(bus_if.o_valid),    32'd0);
    fill_program($urandom_range(3, 20));
    run_program(0, 2, 64);

    // No-halt program running through 0x7FF and wrapping to 0x000.
    fill_program(-1);
    run_program(0, 1, PM_DEPTH + 3);
    apply_reset();
    check_eq("final_idle_rd", 32'(bus_if.o_pm_rd_en), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
